id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register and operand-select stage that directly feeds the ALU inputs data1, data2 and aluoperation.
- Latches decoded ID-stage fields on each clock edge and decodes the 4-bit ALU operation code.
- Drives ALU operands with EX/MEM and MEM/WB forwarding applied, and flags load-use hazards back to ID.
- Passes the remaining control bits on to the EX/MEM register.

---
 rtl/id_ex_operand_stage.sv | 143 ++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with registered ALU decode, EX/MEM and MEM/WB operand
// forwarding, and load-use hazard detection toward the ID stage.
module id_ex_operand_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic [AW-1:0] id_rd,
  input  logic [1:0]    id_aluop,
  input  logic [5:0]    id_funct,
  input  logic          id_alu_src,
  input  logic          id_reg_dst,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          exmem_reg_write,
  input  logic [AW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [AW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] data1,
  output logic [DW-1:0] data2,
  output logic [3:0]    aluoperation,
  output logic [DW-1:0] ex_store_data,
  output logic [AW-1:0] ex_write_reg,
  output logic          ex_valid,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic          illegal_funct,
  output logic          load_use_hazard
);

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_op_e;

  logic [DW-1:0] rs_data_q, rt_data_q, imm_q;
  logic [AW-1:0] rs_q, rt_q;
  logic          alu_src_q;
  alu_op_e       dec_op;
  logic          dec_illegal;
  logic [DW-1:0] fwd_a, fwd_b;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    dec_op      = ALU_ADD;
    dec_illegal = 1'b0;
    unique case (id_aluop)
      2'b00: dec_op = ALU_ADD;
      2'b01: dec_op = ALU_SUB;
      2'b11: dec_op = ALU_OR;
      2'b10: begin
        case (id_funct)
          6'b100000: dec_op = ALU_ADD;
          6'b100010: dec_op = ALU_SUB;
          6'b100100: dec_op = ALU_AND;
          6'b100101: dec_op = ALU_OR;
          6'b101010: dec_op = ALU_SLT;
          default:   dec_illegal = 1'b1;
        endcase
      end
      default: dec_op = ALU_ADD;
    endcase
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      illegal_funct <= 1'b0;
      aluoperation  <= ALU_ADD;
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      imm_q         <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      ex_write_reg  <= '0;
      alu_src_q     <= 1'b0;
    end else if (!stall) begin
      // An invalid slot becomes a bubble for control, but its data still flows.
      ex_valid      <= id_valid;
      ex_reg_write  <= id_valid & id_reg_write & ~dec_illegal;
      ex_mem_read   <= id_valid & id_mem_read;
      ex_mem_write  <= id_valid & id_mem_write;
      ex_mem_to_reg <= id_valid & id_mem_to_reg;
      illegal_funct <= id_valid & dec_illegal;
      aluoperation  <= id_valid ? dec_op : ALU_ADD;
      rs_data_q     <= id_rs_data;
      rt_data_q     <= id_rt_data;
      imm_q         <= id_imm;
      rs_q          <= id_rs;
      rt_q          <= id_rt;
      ex_write_reg  <= id_reg_dst ? id_rd : id_rt;
      alu_src_q     <= id_alu_src;
    end
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB; register 0 is never forwarded.
  always_comb begin
    fwd_a = rs_data_q;
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs_q)
      fwd_a = exmem_result;
    else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs_q)
      fwd_a = memwb_result;
  end

  always_comb begin
    fwd_b = rt_data_q;
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rt_q)
      fwd_b = exmem_result;
    else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rt_q)
      fwd_b = memwb_result;
  end

  assign data1         = fwd_a;
  assign data2         = alu_src_q ? imm_q : fwd_b;
  assign ex_store_data = fwd_b;

  assign load_use_hazard = ex_valid & ex_mem_read & (ex_write_reg != '0) &
                           ((ex_write_reg == id_rs) | (ex_write_reg == id_rt));

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Randomized and directed bench for id_ex_operand_stage against a behavioural
// model of the EX-stage contents.
module tb_id_ex_operand_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst, stall, flush, id_valid;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic [1:0]    id_aluop;
  logic [5:0]    id_funct;
  logic          id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic          exmem_reg_write, memwb_reg_write;
  logic [AW-1:0] exmem_rd, memwb_rd;
  logic [DW-1:0] exmem_result, memwb_result;
  logic [DW-1:0] data1, data2, ex_store_data;
  logic [3:0]    aluoperation;
  logic [AW-1:0] ex_write_reg;
  logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic          illegal_funct, load_use_hazard;

  int total = 0;
  int bad   = 0;

  id_ex_operand_stage #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_aluop(id_aluop), .id_funct(id_funct),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .data1(data1), .data2(data2), .aluoperation(aluoperation), .ex_store_data(ex_store_data),
    .ex_write_reg(ex_write_reg), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .illegal_funct(illegal_funct), .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  // What the EX stage is expected to hold, in instruction terms.
  typedef struct {
    bit            valid, rw, mr, mw, m2r, ill, alu_src;
    logic [3:0]    op;
    logic [DW-1:0] rs_d, rt_d, imm;
    logic [AW-1:0] rs, rt, wr;
  } ex_slot_t;

  ex_slot_t m;
  bit known = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_op(input logic [1:0] aluop, input logic [5:0] funct);
    if (aluop == 2'd0) return 4'd2;
    if (aluop == 2'd1) return 4'd6;
    if (aluop == 2'd3) return 4'd1;
    if (funct == 6'd32) return 4'd2;
    if (funct == 6'd34) return 4'd6;
    if (funct == 6'd36) return 4'd0;
    if (funct == 6'd37) return 4'd1;
    if (funct == 6'd42) return 4'd7;
    return 4'd2;
  endfunction

  function automatic bit ref_illegal(input logic [1:0] aluop, input logic [5:0] funct);
    return aluop == 2'd2 && !(funct inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd42});
  endfunction

  function automatic logic [DW-1:0] ref_fwd(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (a == 0) return d;
    if (exmem_reg_write && exmem_rd == a) return exmem_result;
    if (memwb_reg_write && memwb_rd == a) return memwb_result;
    return d;
  endfunction

  task automatic upd_model();
    if (rst || flush) begin
      m = '{default: 0};
      m.op = 4'd2;
      if (rst) known = 1;
    end else if (!stall) begin
      m.valid   = id_valid;
      m.ill     = id_valid && ref_illegal(id_aluop, id_funct);
      m.rw      = id_valid && id_reg_write && !m.ill;
      m.mr      = id_valid && id_mem_read;
      m.mw      = id_valid && id_mem_write;
      m.m2r     = id_valid && id_mem_to_reg;
      m.op      = id_valid ? ref_op(id_aluop, id_funct) : 4'd2;
      m.rs_d    = id_rs_data;
      m.rt_d    = id_rt_data;
      m.imm     = id_imm;
      m.rs      = id_rs;
      m.rt      = id_rt;
      m.wr      = id_reg_dst ? id_rd : id_rt;
      m.alu_src = id_alu_src;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    upd_model();
    @(negedge clk);
  endtask

  task automatic chk_all();
    logic [DW-1:0] fb;
    bit hz;
    #1;
    if (!known) return;
    fb = ref_fwd(m.rt, m.rt_d);
    hz = m.valid && m.mr && m.wr != 0 && (m.wr == id_rs || m.wr == id_rt);
    check("data1", data1, ref_fwd(m.rs, m.rs_d));
    check("store", ex_store_data, fb);
    check("wreg", ex_write_reg, m.wr);
    check("valid", ex_valid, m.valid);
    check("rw", ex_reg_write, m.rw);
    check("mr", ex_mem_read, m.mr);
    check("mw", ex_mem_write, m.mw);
    check("m2r", ex_mem_to_reg, m.m2r);
    check("illegal", illegal_funct, m.ill);
    check("hazard", load_use_hazard, hz);
    if (m.valid) begin
      check("aluop", aluoperation, m.op);
      check("data2", data2, m.alu_src ? m.imm : fb);
    end
  endtask

  task automatic rand_inputs();
    logic [5:0] functs [6] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};
    id_valid     = ($urandom_range(7) != 0);
    id_rs_data   = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    id_rs        = AW'($urandom_range(7)); id_rt = AW'($urandom_range(7));
    id_rd        = AW'($urandom_range(7));
    id_aluop     = 2'($urandom);
    id_funct     = ($urandom_range(3) == 0) ? 6'($urandom) : functs[$urandom_range(5)];
    id_alu_src   = 1'($urandom); id_reg_dst = 1'($urandom);
    id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
    id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
    exmem_reg_write = 1'($urandom); exmem_rd = AW'($urandom_range(7)); exmem_result = $urandom;
    memwb_reg_write = 1'($urandom); memwb_rd = AW'($urandom_range(7)); memwb_result = $urandom;
  endtask

  task automatic quiet_fwd();
    exmem_reg_write = 0; memwb_reg_write = 0; exmem_rd = 0; memwb_rd = 0;
  endtask

  task automatic load_r(input logic [5:0] funct);
    id_valid = 1; id_aluop = 2'b10; id_funct = funct; id_reg_write = 1;
    id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0; id_alu_src = 0; id_reg_dst = 1;
  endtask

  initial begin
    logic [5:0] sweep_f  [6] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};
    logic [3:0] sweep_op [6] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd7, 4'd2};
    rand_inputs();
    rst = 1; stall = 0; flush = 0;
    @(negedge clk);
    // Reset held two cycles while inputs keep changing.
    for (int i = 0; i < 2; i++) begin
      chk_all(); rand_inputs(); id_valid = 1; cyc();
    end
    #1;
    check("rst_aluop", aluoperation, 4'b0010);
    check("rst_valid", ex_valid, 0);
    check("rst_wreg", ex_write_reg, 0);
    check("rst_data1", data1, 0);
    check("rst_data2", data2, 0);
    rst = 0; load_r(6'd32); id_rd = 5'd9; chk_all(); cyc();
    check("post_rst_valid", ex_valid, 1);
    check("post_rst_wreg", ex_write_reg, 9);

    // Decode sweep for R-type functs.
    for (int i = 0; i < 6; i++) begin
      load_r(sweep_f[i]); chk_all(); cyc(); #1;
      check("sweep_op", aluoperation, sweep_op[i]);
      check("sweep_ill", illegal_funct, i == 5);
      check("sweep_rw", ex_reg_write, i != 5);
    end

    // Forwarding priority and the register-0 exception.
    quiet_fwd(); load_r(6'd32); id_rs = 5; id_rt = 5; id_rs_data = 32'h11; chk_all(); cyc();
    exmem_reg_write = 1; exmem_rd = 5; exmem_result = 32'hAAAA;
    memwb_reg_write = 1; memwb_rd = 5; memwb_result = 32'hBBBB; #1;
    check("fwd_exmem", data1, 32'hAAAA);
    exmem_reg_write = 0; #1;
    check("fwd_memwb", data1, 32'hBBBB);
    quiet_fwd(); id_rs = 0; id_rs_data = 0; chk_all(); cyc();
    exmem_reg_write = 1; memwb_reg_write = 1; exmem_rd = 0; memwb_rd = 0; #1;
    check("fwd_r0", data1, 0);

    // Immediate operand versus forwarded store data.
    quiet_fwd(); id_alu_src = 1; id_imm = 32'hFFFFFFFC; id_rt = 6; id_rt_data = 32'h77;
    chk_all(); cyc();
    exmem_reg_write = 1; exmem_rd = 6; exmem_result = 32'h1234; #1;
    check("imm_data2", data2, 32'hFFFFFFFC);
    check("imm_store", ex_store_data, 32'h1234);

    // Load-use hazard.
    quiet_fwd(); id_valid = 1; id_aluop = 0; id_mem_read = 1; id_reg_dst = 0; id_rt = 8;
    id_reg_write = 1; chk_all(); cyc();
    id_mem_read = 0; id_rs = 8; id_rt = 3; #1;
    check("hazard_hit", load_use_hazard, 1);
    id_mem_read = 1; id_rt = 0; chk_all(); cyc();
    id_mem_read = 0; id_rs = 0; id_rt = 0; #1;
    check("hazard_r0", load_use_hazard, 0);

    // Stall freezes, flush overrides stall, release captures current inputs.
    load_r(6'd34); chk_all(); cyc();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); chk_all(); cyc(); #1;
      check("stall_op", aluoperation, 4'b0110);
      check("stall_valid", ex_valid, 1);
    end
    flush = 1; chk_all(); cyc(); #1;
    check("flush_valid", ex_valid, 0);
    check("flush_op", aluoperation, 4'b0010);
    stall = 0; flush = 0; load_r(6'd37); id_rd = 12; chk_all(); cyc(); #1;
    check("release_op", aluoperation, 4'b0001);
    check("release_wreg", ex_write_reg, 12);

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      rst   = ($urandom_range(49) == 0);
      flush = ($urandom_range(7) == 0);
      stall = ($urandom_range(4) == 0);
      chk_all();
      cyc();
    end
    rst = 0; stall = 0; flush = 0;
    chk_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
